mfcc_frame_sequencer: RTL and testbench

//  Multi-channel overlapped framing front end for the MFCC pipeline; feeds the FFT stage.
//  - Accepts round-robin interleaved audio (ch0,ch1,..,ch0,..) with valid/ready flow control.
//  - Optional per-channel pre-emphasis on input.
//  - Emits frames of FRAME_SIZE samples, hop HOP_SIZE, one channel after another, with
//    sof/eof marks and downstream backpressure.

---
 rtl/mfcc_frame_sequencer.sv | 126 ++++++++++++
 tb/tb_mfcc_frame_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mfcc_frame_sequencer.sv
// mfcc_frame_sequencer: multi-channel overlapped framing front end for the MFCC FFT stage
// Ports:
//    clk, rst (async, active-low), clear (sync flush)
//    audio_in/valid_in/ready_in       : round-robin interleaved input samples
//    frame_out/ch_out/idx_out/sof/eof : registered frame words, channel by channel, oldest first
//    valid_out/ready_out              : output handshake
module mfcc_frame_sequencer #(
   parameter int DATA_WIDTH    = 16,
   parameter int FRAME_SIZE    = 8,
   parameter int HOP_SIZE      = 4,
   parameter int NUM_CH        = 2,
   parameter int PREEMPH_EN    = 1,
   parameter int PREEMPH_SHIFT = 5
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            clear,
   input  logic signed [DATA_WIDTH-1:0]                    audio_in,
   input  logic                                            valid_in,
   output logic                                            ready_in,
   output logic signed [DATA_WIDTH-1:0]                    frame_out,
   output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0]    ch_out,
   output logic [$clog2(FRAME_SIZE)-1:0]                   idx_out,
   output logic                                            sof,
   output logic                                            eof,
   output logic                                            valid_out,
   input  logic                                            ready_out
);
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int AW = $clog2(FRAME_SIZE);
   localparam int NW = $clog2(FRAME_SIZE + 1);
   localparam int PW = DATA_WIDTH + 2;
   localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(FRAME_SIZE - 1);
   localparam logic [NW-1:0] FILL_LAST = NW'(FRAME_SIZE - 1);
   localparam logic [NW-1:0] HOP_LAST  = NW'(HOP_SIZE - 1);

   typedef enum logic [1:0] {FILL, EMIT, HOP} state_t;
   state_t state, state_nx;

   logic [AW-1:0] wp, rd_idx, rd_addr;
   logic [CW-1:0] in_ch, rd_ch;
   logic [NW-1:0] cnt;
   logic pend, xfer_in, set_done, frame_rdy, load, last_out;
   logic signed [DATA_WIDTH-1:0] hist [NUM_CH];
   logic signed [DATA_WIDTH-1:0] mem [NUM_CH][FRAME_SIZE];
   logic signed [DATA_WIDTH-1:0] p, pe;
   logic signed [PW-1:0] pe_full;
   logic pe_ok;

   always_comb begin
      xfer_in   = valid_in & ready_in;
      set_done  = xfer_in && in_ch == LAST_CH;
      frame_rdy = set_done && cnt == (state == FILL ? FILL_LAST : HOP_LAST);
      load      = state == EMIT && pend && (!valid_out || ready_out);
      last_out  = valid_out && ready_out && eof && ch_out == LAST_CH;
      rd_addr   = wp + rd_idx;
      p         = hist[in_ch];
      // x - p + (p >>> shift) needs two guard bits before saturating back to DATA_WIDTH
      pe_full   = {{2{audio_in[DATA_WIDTH-1]}}, audio_in} - {{2{p[DATA_WIDTH-1]}}, p}
                + PW'(p >>> PREEMPH_SHIFT);
      pe_ok     = &pe_full[PW-1:DATA_WIDTH-1] | ~|pe_full[PW-1:DATA_WIDTH-1];
      pe        = PREEMPH_EN == 0 ? audio_in
                : pe_ok           ? pe_full[DATA_WIDTH-1:0]
                : pe_full[PW-1]   ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                :                   {1'b0, {(DATA_WIDTH-1){1'b1}}};
      state_nx  = clear                     ? FILL
                : frame_rdy                 ? EMIT
                : state == EMIT && last_out ? HOP
                :                             state;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= FILL;
      else      state <= state_nx;

   always_ff @(posedge clk)
      if (xfer_in && !clear) mem[in_ch][wp] <= pe;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst || clear) begin
         ready_in  <= rst;
         wp        <= '0;
         in_ch     <= '0;
         cnt       <= '0;
         rd_ch     <= '0;
         rd_idx    <= '0;
         pend      <= 1'b0;
         valid_out <= 1'b0;
         frame_out <= '0;
         ch_out    <= '0;
         idx_out   <= '0;
         sof       <= 1'b0;
         eof       <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) hist[i] <= '0;
      end else begin
         ready_in <= state_nx != EMIT;
         if (xfer_in) begin
            hist[in_ch] <= audio_in;
            in_ch       <= in_ch == LAST_CH ? '0 : in_ch + 1'b1;
            if (in_ch == LAST_CH) wp <= wp + 1'b1;
         end
         if (set_done) cnt <= frame_rdy ? '0 : cnt + 1'b1;
         if (frame_rdy) begin
            rd_ch  <= '0;
            rd_idx <= '0;
            pend   <= 1'b1;
         end
         if (load) begin
            frame_out <= mem[rd_ch][rd_addr];
            ch_out    <= rd_ch;
            idx_out   <= rd_idx;
            sof       <= rd_idx == '0;
            eof       <= rd_idx == LAST_IDX;
            valid_out <= 1'b1;
            rd_idx    <= rd_idx + 1'b1;
            if (rd_idx == LAST_IDX) begin
               rd_ch <= rd_ch == LAST_CH ? '0 : rd_ch + 1'b1;
               pend  <= rd_ch != LAST_CH;
            end
         end else if (valid_out && ready_out) begin
            valid_out <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// tb_mfcc_frame_sequencer: directed checks of framing, hop, backpressure, pre-emphasis, reset and clear
module tb_mfcc_frame_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic a_rst, a_clr, a_vin, a_rdy, a_vout, a_rout, a_sof, a_eof;
   logic signed [15:0] a_in, a_fout;
   logic [0:0] a_ch;
   logic [2:0] a_idx;
   logic b_rst, b_clr, b_vin, b_rdy, b_vout, b_rout, b_sof, b_eof;
   logic signed [15:0] b_in, b_fout;
   logic [0:0] b_ch;
   logic [2:0] b_idx;

   int checks = 0;
   int errors = 0;
   int exp_w [16];

   mfcc_frame_sequencer #(.DATA_WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(4), .NUM_CH(2),
                          .PREEMPH_EN(0), .PREEMPH_SHIFT(5)) dut_a (
      .clk(clk), .rst(a_rst), .clear(a_clr), .audio_in(a_in), .valid_in(a_vin),
      .ready_in(a_rdy), .frame_out(a_fout), .ch_out(a_ch), .idx_out(a_idx),
      .sof(a_sof), .eof(a_eof), .valid_out(a_vout), .ready_out(a_rout));

   mfcc_frame_sequencer #(.DATA_WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(4), .NUM_CH(1),
                          .PREEMPH_EN(1), .PREEMPH_SHIFT(5)) dut_b (
      .clk(clk), .rst(b_rst), .clear(b_clr), .audio_in(b_in), .valid_in(b_vin),
      .ready_in(b_rdy), .frame_out(b_fout), .ch_out(b_ch), .idx_out(b_idx),
      .sof(b_sof), .eof(b_eof), .valid_out(b_vout), .ready_out(b_rout));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic send(input bit sel, input int v);
      int n = 0;
      if (sel) begin b_in = 16'(v); b_vin = 1'b1; end
      else     begin a_in = 16'(v); a_vin = 1'b1; end
      while (!(sel ? b_rdy : a_rdy) && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("send_timeout", 0, 1);
      @(negedge clk);
      a_vin = 1'b0;
      b_vin = 1'b0;
   endtask

   task automatic collect(input bit sel, input int nw, input int stall_k);
      int n = 0;
      while (!(sel ? b_vout : a_vout) && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("collect_timeout", 0, 1);
      for (int k = 0; k < nw; k++) begin
         if (k == stall_k) begin
            if (sel) b_rout = 1'b0; else a_rout = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               chk($sformatf("hold_frame[%0d]", k), sel ? b_fout : a_fout, exp_w[k]);
               chk($sformatf("hold_idx[%0d]", k), sel ? b_idx : a_idx, k % 8);
               chk($sformatf("hold_valid[%0d]", k), sel ? b_vout : a_vout, 1);
            end
            a_rout = 1'b1;
            b_rout = 1'b1;
         end
         chk($sformatf("valid[%0d]", k), sel ? b_vout : a_vout, 1);
         chk($sformatf("frame[%0d]", k), sel ? b_fout : a_fout, exp_w[k]);
         chk($sformatf("ch[%0d]", k), sel ? b_ch : a_ch, k / 8);
         chk($sformatf("idx[%0d]", k), sel ? b_idx : a_idx, k % 8);
         chk($sformatf("sof[%0d]", k), sel ? b_sof : a_sof, (k % 8) == 0);
         chk($sformatf("eof[%0d]", k), sel ? b_eof : a_eof, (k % 8) == 7);
         chk($sformatf("rdy_in[%0d]", k), sel ? b_rdy : a_rdy, 0);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst = 1'b0; a_clr = 1'b0; a_vin = 1'b0; a_in = '0; a_rout = 1'b1;
      b_rst = 1'b0; b_clr = 1'b0; b_vin = 1'b0; b_in = '0; b_rout = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready_in", a_rdy, 0);
      chk("rst_valid_out", a_vout, 0);
      chk("rst_frame_out", a_fout, 0);
      chk("rst_ch_out", a_ch, 0);
      chk("rst_idx_out", a_idx, 0);
      chk("rst_sof", a_sof, 0);
      chk("rst_eof", a_eof, 0);
      chk("rst_b_ready_in", b_rdy, 0);
      a_rst = 1'b1; b_rst = 1'b1;
      #1 chk("release_ready_low", a_rdy, 0);
      @(negedge clk);
      chk("release_ready_high", a_rdy, 1);
      chk("release_b_ready_high", b_rdy, 1);

      // first frame with a 3-cycle stall on ch0 idx 3
      for (int k = 0; k < 16; k++) exp_w[k] = k < 8 ? 2 * k : 2 * (k - 8) + 1;
      for (int v = 0; v < 15; v++) send(0, v);
      chk("fill_no_early_valid", a_vout, 0);
      chk("fill_still_ready", a_rdy, 1);
      send(0, 15);
      chk("emit_ready_drop", a_rdy, 0);
      chk("emit_latency_low", a_vout, 0);
      @(negedge clk);
      chk("emit_latency_high", a_vout, 1);
      collect(0, 16, 3);
      chk("hop_valid_drop", a_vout, 0);
      chk("hop_ready_high", a_rdy, 1);

      // hop of 4 sets
      for (int k = 0; k < 16; k++) exp_w[k] = k < 8 ? 8 + 2 * k : 9 + 2 * (k - 8);
      for (int v = 16; v < 24; v++) send(0, v);
      chk("hop_emit_ready_drop", a_rdy, 0);
      @(negedge clk);
      chk("hop_emit_valid", a_vout, 1);
      collect(0, 16, -1);
      chk("hop2_valid_drop", a_vout, 0);

      // clear during HOP with a simultaneous sample, after a partial set
      for (int v = 100; v < 103; v++) send(0, v);
      a_clr = 1'b1; a_vin = 1'b1; a_in = 16'sd555;
      @(negedge clk);
      a_clr = 1'b0; a_vin = 1'b0;
      chk("clear_ready_high", a_rdy, 1);
      chk("clear_valid_low", a_vout, 0);
      for (int k = 0; k < 16; k++) exp_w[k] = k < 8 ? 2 * k : 2 * (k - 8) + 1;
      for (int v = 0; v < 15; v++) send(0, v);
      chk("clear_no_early_valid", a_vout, 0);
      send(0, 15);
      @(negedge clk);
      chk("clear_emit_valid", a_vout, 1);
      collect(0, 16, -1);

      // reset mid-EMIT at ch1 idx 2
      for (int k = 0; k < 16; k++) exp_w[k] = (k % 8) < 4 ? 8 + (k / 8) + 2 * (k % 8)
                                                          : 200 + (k / 8) + 2 * ((k % 8) - 4);
      for (int v = 200; v < 208; v++) send(0, v);
      collect(0, 10, -1);
      chk("pre_rst_idx", a_idx, 2);
      chk("pre_rst_ch", a_ch, 1);
      a_rst = 1'b0;
      #1;
      chk("mid_rst_valid", a_vout, 0);
      chk("mid_rst_frame", a_fout, 0);
      chk("mid_rst_ch", a_ch, 0);
      chk("mid_rst_idx", a_idx, 0);
      chk("mid_rst_sof", a_sof, 0);
      chk("mid_rst_ready", a_rdy, 0);
      @(negedge clk);
      a_rst = 1'b1;
      #1 chk("rerelease_ready_low", a_rdy, 0);
      @(negedge clk);
      chk("rerelease_ready_high", a_rdy, 1);
      for (int k = 0; k < 16; k++) exp_w[k] = k < 8 ? 300 + 2 * k : 301 + 2 * (k - 8);
      for (int v = 300; v < 315; v++) send(0, v);
      chk("refill_no_valid", a_vout, 0);
      send(0, 315);
      @(negedge clk);
      chk("refill_emit_valid", a_vout, 1);
      collect(0, 16, -1);

      // pre-emphasis with saturation, single channel
      exp_w[0] = 1000; exp_w[1] = 31; exp_w[2] = 31; exp_w[3] = 31798;
      exp_w[4] = -32768; exp_w[5] = 31744; exp_w[6] = 0; exp_w[7] = 0;
      send(1, 1000); send(1, 1000); send(1, 1000); send(1, 32767);
      send(1, -32768); send(1, 0); send(1, 0); send(1, 0);
      @(negedge clk);
      chk("pe_emit_valid", b_vout, 1);
      collect(1, 8, -1);
      chk("pe_valid_drop", b_vout, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
